// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single-port data RAM between the CPU
// memory stage (master 0) and a debug/loader DMA port (master 1).
module data_ram_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_sel,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_stall,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_sel,
   input  logic        m1_lock,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_data_o,
   output logic [3:0]  ram_sel,
   input  logic [31:0] ram_data_i,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   state_t      state;
   state_t      state_nxt;
   logic        owner;
   logic        last;
   logic [3:0]  burst_cnt;
   logic        any_req;
   logic        lock_hit;
   logic        grant;
   logic        own_we;
   logic [31:0] own_addr;
   logic [31:0] own_wdata;
   logic [3:0]  own_sel;

   // Pick the next owner: bounded lock, then lone requester, then round-robin
   always_comb begin
      any_req  = m0_req | m1_req;
      lock_hit = last & m1_lock & m1_req &
                 ((burst_cnt < BURST_LIM) | ~m0_req);
      grant    = 1'b0;
      if (lock_hit) begin
         grant = 1'b1;
      end else if (m0_req ^ m1_req) begin
         grant = m1_req;
      end else begin
         grant = ~last;
      end
   end

   // Next-state logic of the IDLE -> SERVE -> ACK sequencer
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = SERVE;
         SERVE:   state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the owner at grant time; remember it as last once acked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         if (state == IDLE && any_req) owner <= grant;
         if (state == ACK) last <= owner;
      end
   end

   // Count locked master-1 grants so master 0 cannot be starved
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt <= 4'd0;
      end else if (state == IDLE) begin
         if (!m1_lock) begin
            burst_cnt <= 4'd0;
         end else if (any_req && !grant) begin
            burst_cnt <= 4'd0;
         end else if (lock_hit && burst_cnt != 4'hF) begin
            burst_cnt <= burst_cnt + 4'd1;
         end
      end
   end

   // Select the owner's live request fields
   always_comb begin
      own_we    = owner ? m1_we    : m0_we;
      own_addr  = owner ? m1_addr  : m0_addr;
      own_wdata = owner ? m1_wdata : m0_wdata;
      own_sel   = owner ? m1_sel   : m0_sel;
   end

   // Drive the RAM only while serving; quiet bus otherwise
   always_comb begin
      ram_ce     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = 32'd0;
      ram_data_o = 32'd0;
      ram_sel    = 4'd0;
      if (state == SERVE) begin
         ram_ce     = 1'b1;
         ram_we     = own_we;
         ram_addr   = own_addr;
         ram_data_o = own_wdata;
         ram_sel    = own_sel;
      end
   end

   // Capture read data into the owner's register at the end of SERVE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rdata <= 32'd0;
         m1_rdata <= 32'd0;
      end else if (state == SERVE && !own_we) begin
         if (owner) begin
            m1_rdata <= ram_data_i;
         end else begin
            m0_rdata <= ram_data_i;
         end
      end
   end

   assign m0_ack   = (state == ACK) & ~owner;
   assign m1_ack   = (state == ACK) & owner;
   assign m0_stall = m0_req & ~m0_ack;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter: directed checks of the two-master RAM arbiter
// against a small behavioural RAM.
module tb_data_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic [3:0]  m0_sel = '0;
   logic        m0_ack, m0_stall;
   logic [31:0] m0_rdata;
   logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic [3:0]  m1_sel = '0;
   logic        m1_ack;
   logic [31:0] m1_rdata;
   logic        ram_ce, ram_we, busy;
   logic [31:0] ram_addr, ram_data_o, ram_data_i;
   logic [3:0]  ram_sel;

   logic [31:0] mem [0:63];
   logic        mem_init = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          n0, n1;

   data_ram_arbiter #(.MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_ack(m0_ack),
      .m0_rdata(m0_rdata), .m0_stall(m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_lock(m1_lock),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_data_o(ram_data_o), .ram_sel(ram_sel),
      .ram_data_i(ram_data_i), .busy(busy)
   );

   always #5 clk = ~clk;

   assign ram_data_i = ram_ce ? mem[ram_addr[7:2]] : 32'h0;

   // Behavioural RAM: preload, then byte-enabled writes
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
         mem[4]  <= 32'h11223344;
         mem[8]  <= 32'hDEADBEEF;
         mem[17] <= 32'h55667788;
      end else if (ram_ce && ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_sel[b])
               mem[ram_addr[7:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   // Uncontended m0 access: ack expected exactly at t+2
   task automatic m0_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] sel);
      drv();
      m0_req = 1'b1; m0_we = we; m0_addr = addr;
      m0_wdata = wdata; m0_sel = sel;
      @(negedge clk);
      chk1("acc_t0_ack", m0_ack, 1'b0);
      @(negedge clk);
      chk1("acc_t1_ce", ram_ce, 1'b1);
      @(negedge clk);
      chk1("acc_t2_ack", m0_ack, 1'b1);
      drv();
      m0_req = 1'b0;
   endtask

   task automatic pulse_reset();
      drv();
      rst_n = 1'b0;
      drv();
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      mem_init = 1'b1;
      @(negedge clk);
      chk1("rst_m0_ack", m0_ack, 1'b0);
      chk1("rst_m1_ack", m1_ack, 1'b0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      chk("rst_m1_rdata", m1_rdata, 32'h0);
      chk1("rst_ram_ce", ram_ce, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_ram_data_o", ram_data_o, 32'h0);
      chk("rst_ram_sel", 32'(ram_sel), 32'h0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_stall", m0_stall, 1'b0);
      drv();
      rst_n = 1'b1;

      // Reset during SERVE of an m1 write to 0x10
      drv();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10;
      m1_wdata = 32'hCAFEF00D; m1_sel = 4'hF;
      @(negedge clk);
      chk1("mr_t0_busy", busy, 1'b0);
      @(negedge clk);
      chk1("mr_serve_ce", ram_ce, 1'b1);
      chk("mr_serve_addr", ram_addr, 32'h10);
      #2 rst_n = 1'b0;
      #1;
      chk1("mr_rst_ce", ram_ce, 1'b0);
      chk1("mr_rst_we", ram_we, 1'b0);
      chk("mr_rst_addr", ram_addr, 32'h0);
      chk1("mr_rst_busy", busy, 1'b0);
      chk1("mr_rst_ack", m1_ack, 1'b0);
      @(negedge clk);
      chk1("mr_no_ack", m1_ack, 1'b0);
      m1_req = 1'b0; m1_we = 1'b0;
      drv();
      rst_n = 1'b1;
      m0_access(1'b0, 32'h10, 32'h0, 4'hF);
      chk("mr_read_back", m0_rdata, 32'h11223344);

      // Single uncontended read of 0x20
      drv();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; m0_sel = 4'hF;
      @(negedge clk);
      chk1("rd_t0_ce", ram_ce, 1'b0);
      chk1("rd_t0_stall", m0_stall, 1'b1);
      @(negedge clk);
      chk1("rd_t1_ce", ram_ce, 1'b1);
      chk1("rd_t1_we", ram_we, 1'b0);
      chk("rd_t1_addr", ram_addr, 32'h20);
      chk1("rd_t1_stall", m0_stall, 1'b1);
      chk1("rd_t1_busy", busy, 1'b1);
      @(negedge clk);
      chk1("rd_t2_ce", ram_ce, 1'b0);
      chk1("rd_t2_ack", m0_ack, 1'b1);
      chk1("rd_t2_stall", m0_stall, 1'b0);
      chk("rd_t2_rdata", m0_rdata, 32'hDEADBEEF);
      drv();
      m0_req = 1'b0;
      @(negedge clk);
      chk1("rd_t3_ack", m0_ack, 1'b0);
      chk1("rd_t3_busy", busy, 1'b0);

      // Tie-break after reset, then alternation with both held busy
      pulse_reset();
      drv();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; m0_sel = 4'hF;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44; m1_sel = 4'hF;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk1("tie_m0_ack", m0_ack, (i == 2 || i == 8));
         chk1("tie_m1_ack", m1_ack, (i == 5 || i == 11));
         if (i == 5) chk("tie_m1_rdata", m1_rdata, 32'h55667788);
      end
      drv();
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      chk1("tie_idle", busy, 1'b0);

      // m1 byte write to 0x44, byte 1 only
      drv();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44;
      m1_sel = 4'b0010; m1_wdata = 32'h0000AB00;
      @(negedge clk);
      chk1("bw_t0_ack", m1_ack, 1'b0);
      @(negedge clk);
      chk("bw_sel", 32'(ram_sel), 32'h2);
      chk1("bw_we", ram_we, 1'b1);
      chk("bw_data", ram_data_o, 32'h0000AB00);
      @(negedge clk);
      chk1("bw_ack", m1_ack, 1'b1);
      chk("bw_rdata", m1_rdata, 32'h55667788);
      drv();
      m1_req = 1'b0; m1_we = 1'b0;
      @(negedge clk);
      chk1("bw_ack_once", m1_ack, 1'b0);
      chk("bw_mem", mem[17], 32'h5566AB88);
      m0_access(1'b0, 32'h44, 32'h0, 4'hF);
      chk("bw_read_back", m0_rdata, 32'h5566AB88);

      // m0 write with sel = 0 is sequenced but changes nothing
      drv();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20;
      m0_wdata = 32'hFFFFFFFF; m0_sel = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk1("s0_ce", ram_ce, 1'b1);
      chk("s0_sel", 32'(ram_sel), 32'h0);
      @(negedge clk);
      chk1("s0_ack", m0_ack, 1'b1);
      drv();
      m0_req = 1'b0; m0_we = 1'b0;
      @(negedge clk);
      chk("s0_mem", mem[8], 32'hDEADBEEF);
      chk("s0_rdata", m0_rdata, 32'h5566AB88);

      // Locked m1 burst against waiting m0, then m1 alone
      pulse_reset();
      drv();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; m0_sel = 4'hF;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_sel = 4'hF;
      m1_lock = 1'b1;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 39; i++) begin
         @(negedge clk);
         if (i <= 14) begin
            chk1("lk_m0_ack", m0_ack, (i == 14));
            chk1("lk_m1_ack", m1_ack, (i % 3 == 2 && i < 14));
         end else begin
            if (m0_ack) n0++;
            if (m1_ack) n1++;
         end
         if (i == 12) chk("lk_cnt_full", 32'(dut.burst_cnt), 32'd4);
         if (i == 13) chk("lk_cnt_clr", 32'(dut.burst_cnt), 32'd0);
         if (i == 14) m0_req = 1'b0;
      end
      chk("lk_solo_m1", 32'(n1), 32'd8);
      chk("lk_solo_m0", 32'(n0), 32'd0);
      chk("lk_solo_cnt", 32'(dut.burst_cnt), 32'd7);
      m1_req = 1'b0; m1_lock = 1'b0;
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
